// File: rtl/tdm_mux8_tx_pkg.sv
// Shared definitions for the 8-channel TDM transmitter.
//   state_t : frame sequencer states (IDLE, SEND, GAP)
//   NUM_CH  : number of time slots per frame
//   SEL_W   : width of the channel select bus
package tdm_mux8_tx_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot timing for one TDM frame: a 4-bit hold counter that dwells HOLD
// cycles per slot, and a 3-bit channel counter that steps 0..7 and stops
// at the last channel.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   clear      : restart at channel 0, hold 0 (frame entry)
//   adv        : advance one cycle within the frame
//   ch_next    : channel index that will be current after an advance
//   last_slot  : current cycle is the final cycle of the final channel
module tdm_slot_counter
  import tdm_mux8_tx_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             adv,
  output logic [SEL_W-1:0] ch_next,
  output logic             last_slot
);

  localparam logic [3:0]       HOLD_LAST = 4'(HOLD - 1);
  localparam logic [SEL_W-1:0] CH_LAST   = SEL_W'(NUM_CH - 1);

  logic [3:0]       hold_cnt;
  logic [SEL_W-1:0] ch;
  logic             slot_end;

  assign slot_end  = (hold_cnt == HOLD_LAST);
  assign last_slot = slot_end && (ch == CH_LAST);
  // Only meaningful while not on the last slot; the channel never wraps.
  assign ch_next   = slot_end ? ch + SEL_W'(1) : ch;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hold_cnt <= '0;
      ch       <= '0;
    end else if (adv) begin
      if (slot_end) begin
        hold_cnt <= '0;
        if (ch != CH_LAST)
          ch <= ch + SEL_W'(1);
      end else begin
        hold_cnt <= hold_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/tdm_mux8_tx.sv
// 8-to-1 TDM transmitter: latches an 8-bit word and serializes it onto a
// single line, one channel per slot, with the channel select driven
// alongside for a downstream 1-to-8 demultiplexer.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   in_data, in_valid   : parallel word (bit k = channel k) and its valid
//   in_ready            : word accepted when in_valid && in_ready
//   out                 : serialized data line (0 outside a frame)
//   s0, s1, s2          : channel select, index = {s0,s1,s2}
//   busy                : frame or post-frame gap in progress
//   frame_start         : one-cycle pulse on the first cycle of channel 0
// All outputs are registered.
module tdm_mux8_tx
  import tdm_mux8_tx_pkg::*;
#(
  parameter int HOLD     = 1,
  parameter int IDLE_GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic       frame_start
);

  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

  state_t           state;
  logic [7:0]       shadow;
  logic [3:0]       gap_cnt;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] ch_next;
  logic             last_slot;
  logic             accept;
  logic             adv;

  assign accept = (state == IDLE) && in_valid && in_ready;
  assign adv    = (state == SEND) && !last_slot;

  assign {s0, s1, s2} = sel;

  // Counters track the slot currently shown on the outputs; outputs are
  // loaded from the slot that follows.
  tdm_slot_counter #(
    .HOLD (HOLD)
  ) u_slot_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .adv       (adv),
    .ch_next   (ch_next),
    .last_slot (last_slot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shadow      <= '0;
      gap_cnt     <= '0;
      out         <= 1'b0;
      sel         <= '0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          out      <= 1'b0;
          sel      <= '0;
          busy     <= 1'b0;
          if (accept) begin
            shadow      <= in_data;
            state       <= SEND;
            out         <= in_data[0];
            frame_start <= 1'b1;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
          end
        end

        SEND: begin
          if (last_slot) begin
            out     <= 1'b0;
            sel     <= '0;
            gap_cnt <= '0;
            if (IDLE_GAP == 0) begin
              state    <= IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else begin
            out <= shadow[ch_next];
            sel <= ch_next;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_mux8_tx.sv
// Directed bench for tdm_mux8_tx with three parameterizations:
//   u_a : HOLD=1, IDLE_GAP=0
//   u_b : HOLD=3, IDLE_GAP=0
//   u_c : HOLD=1, IDLE_GAP=4
module tb_tdm_mux8_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_data = '0, b_data = '0, c_data = '0;
  logic a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0;
  logic a_ready, a_out, a_s0, a_s1, a_s2, a_busy, a_fs;
  logic b_ready, b_out, b_s0, b_s1, b_s2, b_busy, b_fs;
  logic c_ready, c_out, c_s0, c_s1, c_s2, c_busy, c_fs;

  tdm_mux8_tx #(.HOLD(1), .IDLE_GAP(0)) u_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .out(a_out), .s0(a_s0), .s1(a_s1), .s2(a_s2),
    .busy(a_busy), .frame_start(a_fs));

  tdm_mux8_tx #(.HOLD(3), .IDLE_GAP(0)) u_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .out(b_out), .s0(b_s0), .s1(b_s1), .s2(b_s2),
    .busy(b_busy), .frame_start(b_fs));

  tdm_mux8_tx #(.HOLD(1), .IDLE_GAP(4)) u_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid),
    .in_ready(c_ready), .out(c_out), .s0(c_s0), .s1(c_s1), .s2(c_s2),
    .busy(c_busy), .frame_start(c_fs));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference 1-to-8 demultiplexer: routes the line to output 'sel'.
  function automatic logic [7:0] demux(input logic line, input logic [2:0] sel);
    logic [7:0] r;
    r = '0;
    r[sel] = line;
    return r;
  endfunction

  initial begin
    logic [7:0] pat;
    logic [7:0] word;
    int         seen;

    #1;
    // Reset state
    rst = 1'b1;
    tick();
    chk("rst_out",   32'(a_out),  32'd0);
    chk("rst_sel",   32'({a_s0, a_s1, a_s2}), 32'd0);
    chk("rst_busy",  32'(a_busy), 32'd0);
    chk("rst_fs",    32'(a_fs),   32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_ready_after", 32'(a_ready), 32'd1);
    chk("rst_ready_after_c", 32'(c_ready), 32'd1);

    // HOLD=1: word A5 -> out 1,0,1,0,0,1,0,1 on channels 0..7
    pat = 8'b1010_0101;          // bit k = expected out on channel k
    a_data = 8'hA5; a_valid = 1'b1;
    tick();
    a_valid = 1'b0; a_data = 8'h00;  // must not disturb the frame
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("a5_sel%0d", k), 32'({a_s0, a_s1, a_s2}), 32'(k));
      chk($sformatf("a5_out%0d", k), 32'(a_out), 32'(pat[k]));
      chk($sformatf("a5_fs%0d", k),  32'(a_fs), (k == 0) ? 32'd1 : 32'd0);
      chk($sformatf("a5_busy%0d", k), 32'(a_busy), 32'd1);
      chk($sformatf("a5_rdy%0d", k), 32'(a_ready), 32'd0);
      tick();
    end
    chk("a5_ready_c9", 32'(a_ready), 32'd1);
    chk("a5_busy_c9",  32'(a_busy),  32'd0);
    chk("a5_out_c9",   32'(a_out),   32'd0);

    // HOLD=3: word 81 -> out high cycles 1-3 and 22-24
    b_data = 8'h81; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      chk($sformatf("h3_out_c%0d", c), 32'(b_out), (c <= 3 || c >= 22) ? 32'd1 : 32'd0);
      chk($sformatf("h3_sel_c%0d", c), 32'({b_s0, b_s1, b_s2}), 32'((c - 1) / 3));
      chk($sformatf("h3_busy_c%0d", c), 32'(b_busy), 32'd1);
      tick();
    end
    chk("h3_busy_c25", 32'(b_busy), 32'd0);
    chk("h3_ready_c25", 32'(b_ready), 32'd1);

    // IDLE_GAP=4: continuous valid, FF then 00; re-accept 13 cycles later
    c_data = 8'hFF; c_valid = 1'b1;
    tick();
    c_data = 8'h00;
    seen = 0;
    for (int c = 1; c <= 40 && seen == 0; c++) begin
      if (c <= 8)
        chk($sformatf("gap_send_out_c%0d", c), 32'(c_out), 32'd1);
      else if (c <= 12) begin
        chk($sformatf("gap_out_c%0d", c), 32'(c_out), 32'd0);
        chk($sformatf("gap_busy_c%0d", c), 32'(c_busy), 32'd1);
        chk($sformatf("gap_sel_c%0d", c), 32'({c_s0, c_s1, c_s2}), 32'd0);
        chk($sformatf("gap_rdy_c%0d", c), 32'(c_ready), 32'd0);
      end
      if (c_ready) seen = c;
      tick();
    end
    chk("gap_spacing", 32'(seen), 32'd13);
    chk("gap_second_fs",  32'(c_fs),  32'd1);
    chk("gap_second_out", 32'(c_out), 32'd0);
    c_valid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("gap_done_busy", 32'(c_busy), 32'd0);

    // Reset in the 5th SEND cycle aborts the frame
    a_data = 8'hFF; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_pre_out", 32'(a_out), 32'd1);
    chk("abort_pre_sel", 32'({a_s0, a_s1, a_s2}), 32'd4);
    rst = 1'b1;
    tick();
    chk("abort_out",   32'(a_out),  32'd0);
    chk("abort_sel",   32'({a_s0, a_s1, a_s2}), 32'd0);
    chk("abort_busy",  32'(a_busy), 32'd0);
    chk("abort_ready", 32'(a_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_ready_after", 32'(a_ready), 32'd1);
    chk("abort_no_resume_out",  32'(a_out),  32'd0);
    chk("abort_no_resume_busy", 32'(a_busy), 32'd0);

    // Reset wins over a simultaneous valid
    a_data = 8'hFF; a_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; a_valid = 1'b0;
    tick();
    chk("rst_prio_busy", 32'(a_busy), 32'd0);
    chk("rst_prio_fs",   32'(a_fs),   32'd0);
    chk("rst_prio_out",  32'(a_out),  32'd0);

    // Loopback through the demux model with random words
    for (int w = 0; w < 100; w++) begin
      word = 8'($urandom_range(0, 255));
      chk($sformatf("loop%0d_ready", w), 32'(a_ready), 32'd1);
      a_data = word; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("loop%0d_ch%0d", w, k),
            32'(demux(a_out, {a_s0, a_s1, a_s2})),
            word[k] ? 32'(8'd1 << k) : 32'd0);
        tick();
      end
    end
    chk("loop_idle_out", 32'(a_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
